// File: rtl/projectile_move_multi.sv
// -----------------------------------------------------------------------------
// projectile_move_multi
//   Multi-slot projectile trajectory engine. Each of NUM_SHOTS slots holds a
//   fixed-point (1/2^FRAC_BITS pixel) position and speed. Once per frame every
//   flying slot integrates its position, gains gravity (saturating at
//   MAX_Y_SPEED), and retires when it leaves the playfield. Edge hits reported
//   by the collision logic either retire the slot (BOUNCE_MODE = 0) or reflect
//   its speed (BOUNCE_MODE = 1).
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-clk pulse per frame; triggers integration
//   fire          launch request, sampled every clk
//   hold          freezes integration (position and speed) while high
//   clearAll      synchronous retire of every slot; blocks fire that clk
//   HitEdgeCode   per slot {Left,Top,Right,Bottom}, slot i at [4i+3:4i]
//   topLeftX/Y    per slot 11-bit signed pixel position (floor of fixed point)
//   active        per slot, 1 = in flight
//   fireAck       one-clk registered pulse when a launch is accepted
//   slotsFull     all slots in flight
// -----------------------------------------------------------------------------
module projectile_move_multi #(
    parameter int NUM_SHOTS       = 4,
    parameter int FRAC_BITS       = 6,
    parameter int INITIAL_X       = 610,
    parameter int INITIAL_Y       = 385,
    parameter int INITIAL_X_SPEED = -80,
    parameter int INITIAL_Y_SPEED = 5,
    parameter int Y_ACCEL         = 1,
    parameter int MAX_Y_SPEED     = 230,
    parameter int X_FRAME_MAX     = 635,
    parameter int Y_FRAME_MAX     = 400,
    parameter int BOUNCE_MODE     = 0
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     fire,
    input  logic                     hold,
    input  logic                     clearAll,
    input  logic [4*NUM_SHOTS-1:0]   HitEdgeCode,
    output logic [11*NUM_SHOTS-1:0]  topLeftX,
    output logic [11*NUM_SHOTS-1:0]  topLeftY,
    output logic [NUM_SHOTS-1:0]     active,
    output logic                     fireAck,
    output logic                     slotsFull
);

    typedef enum logic {IDLE = 1'b0, FLY = 1'b1} state_t;

    localparam int          INIT_X_FP  = INITIAL_X * (2 ** FRAC_BITS);
    localparam int          INIT_Y_FP  = INITIAL_Y * (2 ** FRAC_BITS);
    localparam int          X_LIMIT_FP = X_FRAME_MAX * (2 ** FRAC_BITS);
    localparam int          Y_LIMIT_FP = Y_FRAME_MAX * (2 ** FRAC_BITS);
    localparam logic [10:0] INIT_X_PIX = 11'(INITIAL_X);
    localparam logic [10:0] INIT_Y_PIX = 11'(INITIAL_Y);

    state_t             state_q   [NUM_SHOTS];
    state_t             state_d   [NUM_SHOTS];
    logic signed [31:0] pos_x_q   [NUM_SHOTS];
    logic signed [31:0] pos_x_d   [NUM_SHOTS];
    logic signed [31:0] pos_y_q   [NUM_SHOTS];
    logic signed [31:0] pos_y_d   [NUM_SHOTS];
    logic signed [31:0] x_spd_q   [NUM_SHOTS];
    logic signed [31:0] x_spd_d   [NUM_SHOTS];
    logic signed [31:0] y_spd_q   [NUM_SHOTS];
    logic signed [31:0] y_spd_d   [NUM_SHOTS];
    logic               fire_ack_q;
    logic               fire_ack_d;

    logic               found_s;
    int                 launch_idx_s;
    logic [3:0]         hit_s;
    logic signed [31:0] xs_s;
    logic signed [31:0] ys_s;
    logic signed [31:0] nx_s;
    logic signed [31:0] ny_s;
    logic signed [31:0] shx_s;
    logic signed [31:0] shy_s;

    function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
        if (v < 32'sd0) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Next-state logic: launch allocation, edge response, frame integration
    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        x_spd_d      = x_spd_q;
        y_spd_d      = y_spd_q;
        fire_ack_d   = 1'b0;
        found_s      = 1'b0;
        launch_idx_s = 0;
        hit_s        = 4'b0000;
        xs_s         = 32'sd0;
        ys_s         = 32'sd0;
        nx_s         = 32'sd0;
        ny_s         = 32'sd0;

        // Lowest-index idle slot is the launch candidate
        for (int s = 0; s < NUM_SHOTS; s++) begin
            if (!found_s && (state_q[s] == IDLE)) begin
                found_s      = 1'b1;
                launch_idx_s = s;
            end else begin
                found_s      = found_s;
            end
        end

        if (clearAll) begin
            for (int s = 0; s < NUM_SHOTS; s++) begin
                state_d[s] = IDLE;
                pos_x_d[s] = INIT_X_FP;
                pos_y_d[s] = INIT_Y_FP;
                x_spd_d[s] = 32'sd0;
                y_spd_d[s] = 32'sd0;
            end
        end else begin
            fire_ack_d = fire && found_s;
            for (int s = 0; s < NUM_SHOTS; s++) begin
                hit_s = HitEdgeCode[4*s +: 4];
                if (state_q[s] == IDLE) begin
                    // Idle slots ignore hits; a fresh launch skips this frame's integration
                    if (fire && found_s && (launch_idx_s == s)) begin
                        state_d[s] = FLY;
                        pos_x_d[s] = INIT_X_FP;
                        pos_y_d[s] = INIT_Y_FP;
                        x_spd_d[s] = INITIAL_X_SPEED;
                        y_spd_d[s] = INITIAL_Y_SPEED;
                    end else begin
                        state_d[s] = IDLE;
                    end
                end else if ((BOUNCE_MODE == 0) && (hit_s != 4'b0000)) begin
                    // Edge kill beats integration
                    state_d[s] = IDLE;
                    pos_x_d[s] = INIT_X_FP;
                    pos_y_d[s] = INIT_Y_FP;
                    x_spd_d[s] = 32'sd0;
                    y_spd_d[s] = 32'sd0;
                end else begin
                    xs_s = x_spd_q[s];
                    ys_s = y_spd_q[s];
                    // Reflection forces a sign, so a hit lasting several clks is harmless;
                    // opposite edges together leave that axis alone.
                    if (BOUNCE_MODE != 0) begin
                        if (hit_s[3] && !hit_s[1]) begin
                            xs_s = abs32(xs_s);
                        end else if (hit_s[1] && !hit_s[3]) begin
                            xs_s = -abs32(xs_s);
                        end else begin
                            xs_s = xs_s;
                        end
                        if (hit_s[2] && !hit_s[0]) begin
                            ys_s = abs32(ys_s);
                        end else if (hit_s[0] && !hit_s[2]) begin
                            ys_s = -abs32(ys_s);
                        end else begin
                            ys_s = ys_s;
                        end
                    end else begin
                        xs_s = xs_s;
                    end

                    if (startOfFrame && !hold) begin
                        // Position uses the pre-update speed; gravity lands on the reflected speed
                        nx_s = pos_x_q[s] + x_spd_q[s];
                        ny_s = pos_y_q[s] + y_spd_q[s];
                        ys_s = (ys_s < MAX_Y_SPEED) ? (ys_s + Y_ACCEL) : MAX_Y_SPEED;
                        if ((nx_s < 32'sd0) || (nx_s > X_LIMIT_FP) || (ny_s > Y_LIMIT_FP)) begin
                            state_d[s] = IDLE;
                            pos_x_d[s] = INIT_X_FP;
                            pos_y_d[s] = INIT_Y_FP;
                            x_spd_d[s] = 32'sd0;
                            y_spd_d[s] = 32'sd0;
                        end else begin
                            pos_x_d[s] = nx_s;
                            pos_y_d[s] = ny_s;
                            x_spd_d[s] = xs_s;
                            y_spd_d[s] = ys_s;
                        end
                    end else begin
                        x_spd_d[s] = xs_s;
                        y_spd_d[s] = ys_s;
                    end
                end
            end
        end
    end

    // Slot state, fixed-point kinematics and launch acknowledge registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < NUM_SHOTS; s++) begin
                state_q[s] <= IDLE;
                pos_x_q[s] <= INIT_X_FP;
                pos_y_q[s] <= INIT_Y_FP;
                x_spd_q[s] <= 32'sd0;
                y_spd_q[s] <= 32'sd0;
            end
            fire_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            x_spd_q    <= x_spd_d;
            y_spd_q    <= y_spd_d;
            fire_ack_q <= fire_ack_d;
        end
    end

    // Pixel outputs: arithmetic shift floors toward -inf before truncation to 11 bits
    always_comb begin
        shx_s = 32'sd0;
        shy_s = 32'sd0;
        for (int s = 0; s < NUM_SHOTS; s++) begin
            shx_s     = pos_x_q[s] >>> FRAC_BITS;
            shy_s     = pos_y_q[s] >>> FRAC_BITS;
            active[s] = (state_q[s] == FLY);
            if (state_q[s] == FLY) begin
                topLeftX[11*s +: 11] = shx_s[10:0];
                topLeftY[11*s +: 11] = shy_s[10:0];
            end else begin
                topLeftX[11*s +: 11] = INIT_X_PIX;
                topLeftY[11*s +: 11] = INIT_Y_PIX;
            end
        end
    end

    assign slotsFull = &active;
    assign fireAck   = fire_ack_q;

endmodule

// File: tb/tb_projectile_move_multi.sv
// -----------------------------------------------------------------------------
// tb_projectile_move_multi
//   Two instances: A uses the default parameters (retire on edge hit), B uses
//   integer pixels (FRAC_BITS = 0), a low gravity ceiling and reflection, so
//   speed effects are directly visible on its outputs. A behavioural model of
//   each instance is advanced at every clock edge and compared with the DUTs.
// -----------------------------------------------------------------------------
module tb_projectile_move_multi;

    localparam int N = 4;
    // Per-instance parameters: index 0 = A, 1 = B
    localparam int P_F  [2] = '{6, 0};
    localparam int P_IX [2] = '{610, 610};
    localparam int P_IY [2] = '{385, 100};
    localparam int P_VX [2] = '{-80, -3};
    localparam int P_VY [2] = '{5, 5};
    localparam int P_AC [2] = '{1, 1};
    localparam int P_MX [2] = '{230, 8};
    localparam int P_XM [2] = '{635, 635};
    localparam int P_YM [2] = '{400, 1000};
    localparam int P_BM [2] = '{0, 1};

    logic          clk, resetN, sof, fire, hold, clr;
    logic [15:0]   hit_a, hit_b;
    logic [43:0]   x_a, y_a, x_b, y_b;
    logic [3:0]    act_a, act_b;
    logic          ack_a, ack_b, full_a, full_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    bit m_act [2][N];
    int m_px  [2][N];
    int m_py  [2][N];
    int m_xs  [2][N];
    int m_ys  [2][N];
    bit m_ack [2];

    projectile_move_multi #(
        .NUM_SHOTS(N), .FRAC_BITS(6), .INITIAL_X(610), .INITIAL_Y(385),
        .INITIAL_X_SPEED(-80), .INITIAL_Y_SPEED(5), .Y_ACCEL(1), .MAX_Y_SPEED(230),
        .X_FRAME_MAX(635), .Y_FRAME_MAX(400), .BOUNCE_MODE(0)
    ) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .fire(fire), .hold(hold),
        .clearAll(clr), .HitEdgeCode(hit_a), .topLeftX(x_a), .topLeftY(y_a),
        .active(act_a), .fireAck(ack_a), .slotsFull(full_a)
    );

    projectile_move_multi #(
        .NUM_SHOTS(N), .FRAC_BITS(0), .INITIAL_X(610), .INITIAL_Y(100),
        .INITIAL_X_SPEED(-3), .INITIAL_Y_SPEED(5), .Y_ACCEL(1), .MAX_Y_SPEED(8),
        .X_FRAME_MAX(635), .Y_FRAME_MAX(1000), .BOUNCE_MODE(1)
    ) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .fire(fire), .hold(hold),
        .clearAll(clr), .HitEdgeCode(hit_b), .topLeftX(x_b), .topLeftY(y_b),
        .active(act_b), .fireAck(ack_b), .slotsFull(full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Floor division of a fixed-point value by 2^f
    function automatic int floor_pix(input int p, input int f);
        int d;
        d = 1 << f;
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    task automatic retire(input int k, input int s);
        m_act[k][s] = 1'b0;
        m_px[k][s]  = P_IX[k] * (1 << P_F[k]);
        m_py[k][s]  = P_IY[k] * (1 << P_F[k]);
        m_xs[k][s]  = 0;
        m_ys[k][s]  = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < N; s++) retire(k, s);
            m_ack[k] = 1'b0;
        end
    endtask

    // Apply one clock edge of the game rules to instance k
    task automatic model_step(input int k, input logic [15:0] hit);
        int l, nx, ny, xs, ys;
        logic [3:0] h;
        m_ack[k] = 1'b0;
        if (clr) begin
            for (int s = 0; s < N; s++) retire(k, s);
            return;
        end
        l = -1;
        if (fire) begin
            for (int s = N - 1; s >= 0; s--) if (!m_act[k][s]) l = s;
        end
        for (int s = 0; s < N; s++) begin
            if (!m_act[k][s]) continue;
            h = hit[4*s +: 4];
            if (P_BM[k] == 0 && h != 4'b0000) begin
                retire(k, s);
                continue;
            end
            xs = m_xs[k][s];
            ys = m_ys[k][s];
            if (P_BM[k] == 1) begin
                if (h[3] && !h[1]) xs = (xs < 0) ? -xs : xs;
                if (h[1] && !h[3]) xs = (xs < 0) ? xs : -xs;
                if (h[2] && !h[0]) ys = (ys < 0) ? -ys : ys;
                if (h[0] && !h[2]) ys = (ys < 0) ? ys : -ys;
            end
            if (sof && !hold) begin
                nx = m_px[k][s] + m_xs[k][s];
                ny = m_py[k][s] + m_ys[k][s];
                ys = (ys < P_MX[k]) ? ys + P_AC[k] : P_MX[k];
                if (nx < 0 || nx > P_XM[k] * (1 << P_F[k]) || ny > P_YM[k] * (1 << P_F[k])) begin
                    retire(k, s);
                    continue;
                end
                m_px[k][s] = nx;
                m_py[k][s] = ny;
            end
            m_xs[k][s] = xs;
            m_ys[k][s] = ys;
        end
        if (l >= 0) begin
            m_act[k][l] = 1'b1;
            m_px[k][l]  = P_IX[k] * (1 << P_F[k]);
            m_py[k][l]  = P_IY[k] * (1 << P_F[k]);
            m_xs[k][l]  = P_VX[k];
            m_ys[k][l]  = P_VY[k];
            m_ack[k]    = 1'b1;
        end
    endtask

    task automatic check_inst(input int k, input string nm, input logic [3:0] act,
                              input logic ack, input logic full,
                              input logic [43:0] x, input logic [43:0] y);
        logic [3:0]  ea;
        logic [43:0] ex, ey;
        logic [31:0] t;
        for (int s = 0; s < N; s++) begin
            ea[s] = m_act[k][s];
            t = floor_pix(m_px[k][s], P_F[k]);
            ex[11*s +: 11] = t[10:0];
            t = floor_pix(m_py[k][s], P_F[k]);
            ey[11*s +: 11] = t[10:0];
        end
        chk({nm, "_active"}, act, ea);
        chk({nm, "_fireAck"}, ack, m_ack[k]);
        chk({nm, "_slotsFull"}, full, &ea);
        chk({nm, "_topLeftX"}, x, ex);
        chk({nm, "_topLeftY"}, y, ey);
    endtask

    task automatic check_all();
        check_inst(0, "A", act_a, ack_a, full_a, x_a, y_a);
        check_inst(1, "B", act_b, ack_b, full_b, x_b, y_b);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, hit_a);
        model_step(1, hit_b);
        #1;
        check_all();
    endtask

    initial begin
        int          acks;
        logic [10:0] xb0;
        logic [43:0] sx_a, sy_a, sx_b, sy_b;

        resetN = 1'b0; sof = 1'b0; fire = 1'b0; hold = 1'b0; clr = 1'b0;
        hit_a = 16'h0000; hit_b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        chk("rst_active", act_a, 4'b0000);
        chk("rst_x0", x_a[10:0], 11'd610);
        resetN = 1'b1;
        tick();

        // Launch and first frames
        fire = 1'b1; tick();
        chk("launch_ack", ack_a, 1'b1);
        chk("launch_active", act_a, 4'b0001);
        fire = 1'b0; sof = 1'b1; tick();
        chk("f1_x0", x_a[10:0], 11'd608);
        chk("f1_y0", y_a[10:0], 11'd385);
        chk("f1_yb", y_b[10:0], 11'd105);
        tick();
        chk("f2_x0", x_a[10:0], 11'd607);
        chk("f2_yb", y_b[10:0], 11'd111);
        repeat (3) tick();
        chk("sat_yb", y_b[10:0], 11'd134);
        sof = 1'b0;

        // clearAll beats fire
        clr = 1'b1; fire = 1'b1; tick();
        chk("clr_active", act_a, 4'b0000);
        chk("clr_ack", ack_a, 1'b0);
        clr = 1'b0;

        // Fire held past full
        acks = 0;
        repeat (5) begin
            tick();
            acks += int'(ack_a);
        end
        chk("ack_count", acks, 4);
        chk("full", full_a, 1'b1);
        chk("drop_ack", ack_a, 1'b0);
        fire = 1'b0;

        // Edge kill on slot 2, then reuse
        hit_a = 16'h0200; tick(); hit_a = 16'h0000;
        chk("kill_active", act_a, 4'b1011);
        chk("kill_x2", x_a[32:22], 11'd610);
        chk("kill_y2", y_a[32:22], 11'd385);
        fire = 1'b1; tick(); fire = 1'b0;
        chk("reuse_active", act_a, 4'b1111);

        // Reflection on B slot 0
        hit_b = 16'h0008; tick(); hit_b = 16'h0000;
        xb0 = x_b[10:0];
        sof = 1'b1; tick();
        chk("bounce_left", x_b[10:0], xb0 + 11'd3);
        xb0 = x_b[10:0];
        hit_b = 16'h000A; tick();
        chk("bounce_lr", x_b[10:0], xb0 + 11'd3);
        xb0 = x_b[10:0];
        hit_b = 16'h0002; tick(); hit_b = 16'h0000;
        chk("bounce_right_old", x_b[10:0], xb0 + 11'd3);
        xb0 = x_b[10:0];
        tick();
        chk("bounce_right_new", x_b[10:0], xb0 - 11'd3);

        // Hold freezes everything across frames
        hold = 1'b1;
        sx_a = x_a; sy_a = y_a; sx_b = x_b; sy_b = y_b;
        repeat (3) tick();
        chk("hold_xa", x_a, sx_a);
        chk("hold_ya", y_a, sy_a);
        chk("hold_xb", x_b, sx_b);
        chk("hold_yb", y_b, sy_b);
        hold = 1'b0;
        tick();
        sof = 1'b0;

        // Randomised traffic
        repeat (1500) begin
            fire  = ($urandom_range(0, 3) == 0);
            sof   = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            clr   = ($urandom_range(0, 199) == 0);
            hit_a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0000;
            hit_b = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000;
            tick();
        end
        fire = 1'b0; sof = 1'b0; hold = 1'b0; clr = 1'b0;
        hit_a = 16'h0000; hit_b = 16'h0000;

        // Asynchronous reset mid-flight
        fire = 1'b1; tick(); fire = 1'b0;
        sof = 1'b1; tick(); sof = 1'b0;
        #3;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_active", act_a, 4'b0000);
        chk("arst_ack", ack_a, 1'b0);
        chk("arst_x0", x_a[10:0], 11'd610);
        @(negedge clk);
        resetN = 1'b1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/projectile_move_multi.md
Name: projectile_move_multi

Overview:
- Parametrised multi-shot successor to the single-cannon trajectory block.
- Manages NUM_SHOTS independent projectiles. Each has 1/2^FRAC_BITS-pixel fixed-point position, per-frame gravity with saturation, and configurable edge response (retire or reflect).
- Sits between the game controller (fire/hold/clear) and the per-shot drawing and collision-detection logic, which return per-shot HitEdgeCode.

Parameters:
- NUM_SHOTS, 4, number of projectile slots (1..8)
- FRAC_BITS, 6, fixed-point fraction bits (multiplier 2^FRAC_BITS)
- INITIAL_X, 610, launch/idle X in pixels
- INITIAL_Y, 385, launch/idle Y in pixels
- INITIAL_X_SPEED, -80, launch X speed, fixed-point units per frame (signed)
- INITIAL_Y_SPEED, 5, launch Y speed, fixed-point units per frame (signed)
- Y_ACCEL, 1, added to Yspeed each frame
- MAX_Y_SPEED, 230, Yspeed saturation ceiling
- X_FRAME_MAX, 635, retire when X exceeds this, in pixels
- Y_FRAME_MAX, 400, retire when Y exceeds this, in pixels
- BOUNCE_MODE, 0, 0 = retire on edge hit; 1 = reflect on edge hit

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clk pulse per frame
- fire  in  1  launch request, sampled every clk
- hold  in  1  freeze all integration while high
- clearAll  in  1  synchronous retire of all slots
- HitEdgeCode  in  4*NUM_SHOTS  per slot {Left,Top,Right,Bottom}; slot i at [4i+3:4i]
- topLeftX  out  11*NUM_SHOTS  signed pixel X per slot
- topLeftY  out  11*NUM_SHOTS  signed pixel Y per slot
- active  out  NUM_SHOTS  1 = slot in flight
- fireAck  out  1  one-clk pulse, launch accepted
- slotsFull  out  1  all slots active

Behaviour:
- Reset (async): all slots IDLE; posX/posY = INITIAL*2^FRAC_BITS; Xspeed = Yspeed = 0; fireAck = 0; slotsFull = 0; active = 0.
- Per-slot FSM has two states, IDLE and FLY. State, 32-bit signed positions and speeds are all registered.
- Launch:
  - fire = 1 and at least one IDLE slot: the lowest-index IDLE slot enters FLY at the next edge.
  - That slot loads pos = INITIAL*2^FRAC_BITS, Xspeed = INITIAL_X_SPEED, Yspeed = INITIAL_Y_SPEED.
  - fireAck = 1 for exactly that cycle (registered, one clk).
  - Only one launch per clk. A fire held high launches one slot per clk until all are full.
  - With no IDLE slot, fire is dropped and fireAck stays 0.
- Integration, on startOfFrame = 1 and hold = 0, for each FLY slot not launched this clk:
  - pos += speed, using pre-update speeds.
  - Yspeed += Y_ACCEL if Yspeed < MAX_Y_SPEED, else Yspeed = MAX_Y_SPEED.
  - hold = 1 freezes both position and speed.
- Auto-retire: if the new posX < 0, posX > X_FRAME_MAX*2^FRAC_BITS, or posY > Y_FRAME_MAX*2^FRAC_BITS, the slot goes IDLE at that edge and its position reloads INITIAL. This applies in both modes.
- Edge hit (any clk, FLY slot, any HitEdgeCode bit set):
  - BOUNCE_MODE = 0: slot goes IDLE next edge; position reloads INITIAL; speeds go to 0.
  - BOUNCE_MODE = 1, per bit:
    - Left: Xspeed = +|Xspeed|
    - Right: Xspeed = -|Xspeed|
    - Top: Yspeed = +|Yspeed|
    - Bottom: Yspeed = -|Yspeed|
  - Reflection is idempotent, so a multi-cycle hit is harmless.
  - Left+Right (or Top+Bottom) together: that axis is unchanged.
  - HitEdgeCode is ignored for IDLE slots.
- Simultaneous events:
  - clearAll has priority over everything except reset. All slots go IDLE and fire is ignored that clk.
  - Edge hit in mode 0 together with startOfFrame: retire wins, no integration.
  - Mode 1 reflection together with startOfFrame: integration uses the old speed; the reflected value is written to the speed register and Y_ACCEL is applied after reflection.
  - A slot launched on a startOfFrame clk is not integrated in that frame.
- Outputs:
  - topLeftX/Y = fixed-point >>> FRAC_BITS (arithmetic shift, floor toward -inf), truncated to 11 bits, combinational from registers.
  - IDLE slots output INITIAL_X/INITIAL_Y.
  - active[i] = (state_i == FLY).
  - slotsFull = &active.

Test Plan:
- Launch and first frame: reset, fire 1 clk -> fireAck = 1, active = 0001. Then startOfFrame -> X0 = 608 (38960/64 floor), Y0 = 385 (24645). Second frame -> raw X 38880 -> X0 = 607; raw Y = 24651.
- Slot allocation and full: fire held 5 clks, NUM_SHOTS = 4 -> fireAck high 4 clks, active = 1111, slotsFull = 1. Fifth request dropped. Retire slot 2, then fire -> slot 2 reused.
- Gravity saturation: MAX_Y_SPEED = 8, fire, 5 frames -> Yspeed sequence 6, 7, 8, 8, 8.
- Edge kill, BOUNCE_MODE = 0: slot 1 in flight, HitEdgeCode[7:4] = 0010 for 1 clk -> active[1] = 0 next clk, topLeftX[1] = 610, topLeftY[1] = 385.
- Bounce, BOUNCE_MODE = 1: Left hit on slot 0 with Xspeed = -80 -> Xspeed = +80; next frame raw X increases by 80. Left+Right together -> Xspeed unchanged.
- Hold and clear: hold = 1 across 3 startOfFrame -> positions and speeds constant. clearAll with fire same clk -> active = 0000, fireAck = 0. resetN low mid-flight -> all outputs at reset values immediately.
